hs_npu_axi_rd_slice: RTL
========================

HS_NPU_AXI_RD_SLICE -- requirements
Module: hs_npu_axi_rd_slice

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AR address width.
REQ-002 SHALL have parameter DATA_W, default 32, R data width; legal values 32/64/128.
REQ-003 SHALL have parameter ID_W, default 8, AR/R ID width.
REQ-004 SHALL have parameter MAX_OUTST, default 4, maximum accepted-but-incomplete read bursts; range 1..255.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 s_ar_valid / s_ar_ready  in / out  1 / 1  upstream (NPU master) AR handshake.
REQ-008 s_ar_pld  in  ID_W+ADDR_W+13  packed {id, len[7:0], addr, size[2:0], burst[1:0]}, MSB first.
REQ-009 m_ar_valid / m_ar_ready  out / in  1 / 1  downstream (memory) AR handshake.
REQ-010 m_ar_pld  out  ID_W+ADDR_W+13  same packing as s_ar_pld.
REQ-011 m_r_valid / m_r_ready  in / out  1 / 1  downstream R handshake.
REQ-012 m_r_pld  in  ID_W+DATA_W+3  packed {id, data, resp[1:0], last}.
REQ-013 s_r_valid / s_r_ready  out / in  1 / 1  upstream R handshake.
REQ-014 s_r_pld  out  ID_W+DATA_W+3  same packing as m_r_pld.
REQ-015 outst_cnt  out  $clog2(MAX_OUTST+1)  current outstanding-burst count.
REQ-016 err_clr  in  1  synchronous clear of the error record.
REQ-017 err_flag / err_id  out / out  1 / ID_W  sticky read-error flag and ID of first erroring beat.

Function
REQ-018 AR and R channels SHALL each pass through an independent 2-entry skid buffer: full throughput (1 beat/cycle) with no combinational path from any ready to any ready or valid.
REQ-019 Forward latency per channel SHALL be exactly 1 cycle when the buffer is empty and the sink is ready.
REQ-020 s_ar_ready and m_r_ready SHALL be registered and equal "buffer holds fewer than 2 entries".
REQ-021 Payload SHALL be forwarded bit-exact; beat order SHALL be preserved; no beat dropped or duplicated.
REQ-022 Once a valid output is asserted, it and its payload SHALL remain stable until the handshake completes (AXI rule).
REQ-023 outst_cnt SHALL increment on m_ar_valid&&m_ar_ready and decrement on s_r_valid&&s_r_ready&&last; simultaneous increment and decrement SHALL leave it unchanged.
REQ-024 m_ar_valid SHALL be (AR buffer non-empty) AND (outst_cnt < MAX_OUTST); because the count rises only on an AR handshake, this never withdraws an asserted valid.
REQ-025 At outst_cnt == MAX_OUTST, AR SHALL stall and the buffer SHALL still accept up to 2 upstream requests; a same-cycle last-beat decrement SHALL not release AR until the following cycle.
REQ-026 A last beat with outst_cnt == 0 (protocol violation) SHALL be forwarded and SHALL leave the counter at 0 (no underflow).

Reset
REQ-027 While rst_n is low: both buffers empty; s_r_valid, m_ar_valid, s_ar_ready, m_r_ready, err_flag = 0; outst_cnt = 0; err_id = 0; payload outputs = 0.
REQ-028 s_ar_ready and m_r_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-029 Reset asserted mid-burst SHALL discard all buffered beats and the counter with no partial output afterwards.

Configuration
REQ-030 With HS_NPU_RD_SLICE_ERR_EN defined: on the first s_r handshake with resp != 2'b00 while err_flag = 0, err_flag SHALL set and err_id SHALL capture that beat's id; later errors SHALL not overwrite; err_clr SHALL clear both next cycle, and an error in the same cycle as err_clr SHALL win.
REQ-031 Without HS_NPU_RD_SLICE_ERR_EN: err_flag and err_id SHALL be constant 0, err_clr ignored, no error registers synthesised.

Verification
REQ-032 Single AR (id=3, len=3, addr=0x1000) then 4 R beats with sinks always ready -> each appears 1 cycle later unchanged; outst_cnt 0->1->0.
REQ-033 MAX_OUTST=2, 3 back-to-back ARs, no R -> 2 forwarded, third held, outst_cnt=2, s_ar_ready stays 1 until buffer full; a last beat releases third AR next cycle.
REQ-034 Random 50% m_ar_ready/s_r_ready backpressure, 1000 beats -> scoreboard exact in-order match, no valid drop while stalled.
REQ-035 ERR_EN build: beats resp=2 (id=5) then resp=3 (id=7) -> err_flag=1, err_id=5; err_clr -> 0 next cycle.
REQ-036 rst_n pulsed low mid-burst with 2 beats buffered -> all valids 0, outst_cnt=0, no stale beat after release.

Source files
------------

// File: rtl/hs_npu_axi_rd_slice.sv
// hs_npu_axi_rd_slice: AXI read-path register slice with 2-entry skid buffers and outstanding-burst limiter.
// Optional sticky read-error capture enabled by defining HS_NPU_RD_SLICE_ERR_EN.
module hs_npu_axi_rd_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_pld,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_pld
);
  logic [1:0]   cnt_q, cnt_d;
  logic         rdy_q, rdy_d;
  logic [W-1:0] head_q, head_d, skid_q, skid_d;
  logic         push, pop;
  always_comb begin
    push   = in_valid && rdy_q;
    pop    = (cnt_q != 2'd0) && out_ready;
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    head_d = (push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop))) ? in_pld :
             (pop && cnt_q == 2'd2) ? skid_q : head_q;
    skid_d = (push && cnt_q == 2'd1 && !pop) ? in_pld : skid_q;
    rdy_d  = cnt_d != 2'd2;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rdy_q  <= 1'b0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      rdy_q  <= rdy_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end
  assign in_ready  = rdy_q;
  assign out_valid = cnt_q != 2'd0;
  assign out_pld   = head_q;
endmodule

module hs_npu_axi_rd_slice #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               s_ar_valid,
  output logic                               s_ar_ready,
  input  logic [ID_W+ADDR_W+12:0]            s_ar_pld,
  output logic                               m_ar_valid,
  input  logic                               m_ar_ready,
  output logic [ID_W+ADDR_W+12:0]            m_ar_pld,
  input  logic                               m_r_valid,
  output logic                               m_r_ready,
  input  logic [ID_W+DATA_W+2:0]             m_r_pld,
  output logic                               s_r_valid,
  input  logic                               s_r_ready,
  output logic [ID_W+DATA_W+2:0]             s_r_pld,
  output logic [$clog2(MAX_OUTST+1)-1:0]     outst_cnt,
  input  logic                               err_clr,
  output logic                               err_flag,
  output logic [ID_W-1:0]                    err_id
);
  localparam int CW = $clog2(MAX_OUTST+1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);
  logic          ar_buf_v, ar_ok, ar_fire, r_fire, dec;
  logic [CW-1:0] outst_q, outst_d;
  hs_npu_axi_rd_slice_skid #(.W(ID_W+ADDR_W+13)) u_ar (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_ar_valid), .in_ready(s_ar_ready), .in_pld(s_ar_pld),
    .out_valid(ar_buf_v), .out_ready(m_ar_ready && ar_ok), .out_pld(m_ar_pld)
  );
  hs_npu_axi_rd_slice_skid #(.W(ID_W+DATA_W+3)) u_r (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_r_valid), .in_ready(m_r_ready), .in_pld(m_r_pld),
    .out_valid(s_r_valid), .out_ready(s_r_ready), .out_pld(s_r_pld)
  );
  // Gating on the registered count means a freeing last beat only releases AR a cycle later.
  always_comb begin
    ar_ok   = outst_q < MAX_C;
    ar_fire = ar_buf_v && ar_ok && m_ar_ready;
    r_fire  = s_r_valid && s_r_ready;
    dec     = r_fire && s_r_pld[0];
    outst_d = (ar_fire && !dec) ? outst_q + CW'(1) :
              (dec && !ar_fire && outst_q != '0) ? outst_q - CW'(1) : outst_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outst_q <= '0;
    else        outst_q <= outst_d;
  end
  assign m_ar_valid = ar_buf_v && ar_ok;
  assign outst_cnt  = outst_q;
`ifdef HS_NPU_RD_SLICE_ERR_EN
  logic            err_flag_q, err_flag_d, err_hit, err_cap;
  logic [ID_W-1:0] err_id_q, err_id_d;
  always_comb begin
    err_hit    = r_fire && s_r_pld[2:1] != 2'b00;
    err_cap    = err_hit && (!err_flag_q || err_clr);
    err_flag_d = err_cap ? 1'b1 : err_clr ? 1'b0 : err_flag_q;
    err_id_d   = err_cap ? s_r_pld[ID_W+DATA_W+2 -: ID_W] : err_clr ? '0 : err_id_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_q <= 1'b0;
      err_id_q   <= '0;
    end else begin
      err_flag_q <= err_flag_d;
      err_id_q   <= err_id_d;
    end
  end
  assign err_flag = err_flag_q;
  assign err_id   = err_id_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_flag       = 1'b0;
  assign err_id         = '0;
`endif
endmodule
